// File: rtl/beta_decode_issue_pkg.sv
// Shared types for the Beta decode/issue stage.
// ALU function encoding, opcodes and the register-format layout.
package beta_decode_issue_pkg;

  localparam logic [4:0] R31 = 5'd31;

  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_SUB   = 6'h21;
  localparam logic [5:0] OP_MUL   = 6'h22;
  localparam logic [5:0] OP_DIV   = 6'h23;
  localparam logic [5:0] OP_CMPEQ = 6'h24;
  localparam logic [5:0] OP_CMPLT = 6'h25;
  localparam logic [5:0] OP_CMPLE = 6'h26;
  localparam logic [5:0] OP_AND   = 6'h28;
  localparam logic [5:0] OP_OR    = 6'h29;
  localparam logic [5:0] OP_XOR   = 6'h2A;
  localparam logic [5:0] OP_SHL   = 6'h2C;
  localparam logic [5:0] OP_SHR   = 6'h2D;
  localparam logic [5:0] OP_SRA   = 6'h2E;

  typedef enum logic [3:0] {
    FN_ADD, FN_SUB, FN_MUL, FN_DIV,
    FN_CMPEQ, FN_CMPLT, FN_CMPLE,
    FN_AND, FN_OR, FN_XOR,
    FN_SHL, FN_SHR, FN_SRA,
    FN_NOP
  } alu_fn_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [10:0] unused;
  } inst_reg;

  typedef struct packed {
    alu_fn_t fn;
    logic    illegal;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d.fn = FN_NOP;
    d.illegal = 1'b0;
    unique case (1'b1)
      (op == OP_ADD):   d.fn = FN_ADD;
      (op == OP_SUB):   d.fn = FN_SUB;
      (op == OP_MUL):   d.fn = FN_MUL;
      (op == OP_DIV):   d.fn = FN_DIV;
      (op == OP_CMPEQ): d.fn = FN_CMPEQ;
      (op == OP_CMPLT): d.fn = FN_CMPLT;
      (op == OP_CMPLE): d.fn = FN_CMPLE;
      (op == OP_AND):   d.fn = FN_AND;
      (op == OP_OR):    d.fn = FN_OR;
      (op == OP_XOR):   d.fn = FN_XOR;
      (op == OP_SHL):   d.fn = FN_SHL;
      (op == OP_SHR):   d.fn = FN_SHR;
      (op == OP_SRA):   d.fn = FN_SRA;
      default:          d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/beta_instr_fifo.sv
// Small synchronous instruction FIFO with registered pointers.
// Flags derive from the pointers only, so full never depends on same-cycle reads.
module beta_instr_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_wr;
  logic         do_rd;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/beta_decode_issue.sv
// Beta decode/issue stage: FIFO, decode, register scoreboard,
// single-entry issue register and saturating statistics.
module beta_decode_issue
  import beta_decode_issue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_dest,
  output logic             iss_valid,
  input  logic             iss_ready,
  output alu_fn_t          iss_fn,
  output logic [4:0]       iss_src1,
  output logic [4:0]       iss_src2,
  output logic [4:0]       iss_dest,
  output logic             iss_illegal,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic        full;
  logic        empty;
  logic [31:0] head_raw;
  inst_reg     head;
  dec_t        dec;
  logic        head_valid;
  logic        hit;
  logic        blocked;
  logic        load;
  logic [31:0] busy_nxt;
  logic [10:0] unused_bits;

  assign in_ready = rst_n && !full;

  beta_instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid && in_ready),
    .wr_data (instr),
    .rd_en   (load),
    .rd_data (head_raw),
    .full    (full),
    .empty   (empty)
  );

  assign head        = inst_reg'(head_raw);
  assign unused_bits = head.unused;
  assign dec         = decode(head.op);
  assign head_valid  = !empty;

  // R31 is hardwired zero, so it never participates in hazards
  assign hit = (head.src1 != R31 && busy_mask[head.src1]) ||
               (head.src2 != R31 && busy_mask[head.src2]) ||
               (head.dest != R31 && busy_mask[head.dest]);

  assign blocked = head_valid && !dec.illegal && hit;
  assign load    = head_valid && !blocked &&
                   (!iss_valid || iss_ready);

  always_comb begin
    busy_nxt = busy_mask;
    if (wb_valid) busy_nxt[wb_dest] = 1'b0;
    if (load && !dec.illegal && head.dest != R31)
      busy_nxt[head.dest] = 1'b1;
    busy_nxt[R31] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid   <= 1'b0;
      iss_fn      <= FN_ADD;
      iss_src1    <= '0;
      iss_src2    <= '0;
      iss_dest    <= '0;
      iss_illegal <= 1'b0;
    end else if (load) begin
      iss_valid   <= 1'b1;
      iss_fn      <= dec.fn;
      iss_src1    <= head.src1;
      iss_src2    <= head.src2;
      iss_dest    <= head.dest;
      iss_illegal <= dec.illegal;
    end else if (iss_ready) begin
      iss_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
      issue_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      busy_mask <= busy_nxt;
      if (iss_valid && iss_ready && issue_cnt != '1)
        issue_cnt <= issue_cnt + CNT_W'(1);
      if (blocked && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_beta_decode_issue.sv
// Self-checking bench for beta_decode_issue: vector table plus
// directed hazard, backpressure, illegal, R31 and reset sequences.
module tb_beta_decode_issue;
  import beta_decode_issue_pkg::*;

  typedef struct packed {
    alu_fn_t    fn;
    logic [4:0] s1;
    logic [4:0] s2;
    logic [4:0] d;
    logic       ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    alu_fn_t     fn;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  alu_fn_t     iss_fn;
  logic [4:0]  iss_src1;
  logic [4:0]  iss_src2;
  logic [4:0]  iss_dest;
  logic        iss_illegal;
  logic [31:0] busy_mask;
  logic [15:0] issue_cnt;
  logic [15:0] stall_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur_exp;

  beta_decode_issue #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_fn(iss_fn), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_dest(iss_dest), .iss_illegal(iss_illegal),
    .busy_mask(busy_mask), .issue_cnt(issue_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(logic [5:0] op, logic [4:0] a,
                                     logic [4:0] b, logic [4:0] d);
    return {op, a, b, d, 11'h5a5};
  endfunction

  function automatic exp_t model(logic [31:0] i);
    exp_t e;
    e.s1 = i[25:21];
    e.s2 = i[20:16];
    e.d = i[15:11];
    e.ill = 1'b0;
    case (i[31:26])
      6'h20: e.fn = FN_ADD;
      6'h21: e.fn = FN_SUB;
      6'h22: e.fn = FN_MUL;
      6'h23: e.fn = FN_DIV;
      6'h24: e.fn = FN_CMPEQ;
      6'h25: e.fn = FN_CMPLT;
      6'h26: e.fn = FN_CMPLE;
      6'h28: e.fn = FN_AND;
      6'h29: e.fn = FN_OR;
      6'h2A: e.fn = FN_XOR;
      6'h2C: e.fn = FN_SHL;
      6'h2D: e.fn = FN_SHR;
      6'h2E: e.fn = FN_SRA;
      default: begin e.fn = FN_NOP; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (iss_valid && iss_ready) begin
        if (q.size() == 0) chk("spurious_issue", 1, 0);
        else chk("issue_payload",
                 {iss_fn, iss_src1, iss_src2, iss_dest, iss_illegal},
                 q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] i);
    instr = i;
    in_valid = 1'b1;
    cur_exp = model(i);
  endtask

  task automatic wb(logic [4:0] r);
    wb_valid = 1'b1;
    wb_dest = r;
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 30; c++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    wb_valid = 1'b0;
    iss_ready = 1'b0;
    q.delete();
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  vec_t vt[15];
  logic [31:0] mask;
  int acc;
  logic go;

  initial begin
    vt[0]  = '{mk(6'h20, 20, 21, 1),  FN_ADD,   1'b0};
    vt[1]  = '{mk(6'h21, 20, 21, 2),  FN_SUB,   1'b0};
    vt[2]  = '{mk(6'h22, 20, 21, 3),  FN_MUL,   1'b0};
    vt[3]  = '{mk(6'h23, 20, 21, 4),  FN_DIV,   1'b0};
    vt[4]  = '{mk(6'h24, 20, 21, 5),  FN_CMPEQ, 1'b0};
    vt[5]  = '{mk(6'h25, 20, 21, 6),  FN_CMPLT, 1'b0};
    vt[6]  = '{mk(6'h26, 20, 21, 7),  FN_CMPLE, 1'b0};
    vt[7]  = '{mk(6'h28, 20, 21, 8),  FN_AND,   1'b0};
    vt[8]  = '{mk(6'h29, 20, 21, 9),  FN_OR,    1'b0};
    vt[9]  = '{mk(6'h2A, 20, 21, 10), FN_XOR,   1'b0};
    vt[10] = '{mk(6'h2C, 20, 21, 11), FN_SHL,   1'b0};
    vt[11] = '{mk(6'h2D, 20, 21, 12), FN_SHR,   1'b0};
    vt[12] = '{mk(6'h2E, 20, 21, 13), FN_SRA,   1'b0};
    vt[13] = '{mk(6'h27, 20, 21, 14), FN_NOP,   1'b1};
    vt[14] = '{mk(6'h00, 20, 21, 15), FN_NOP,   1'b1};

    // reset state
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_cnts", {issue_cnt, stall_cnt}, 0);
    reset_dut();
    chk("post_rst_in_ready", in_ready, 1);

    // basic ADD r1,r2->r3
    iss_ready = 1'b1;
    send(32'h80221801);
    cyc();
    in_valid = 1'b0;
    chk("add_not_yet", iss_valid, 0);
    cyc();
    chk("add_valid", iss_valid, 1);
    chk("add_busy", busy_mask, 32'h8);
    cyc();
    chk("add_issue_cnt", issue_cnt, 1);
    wb(5'd3);
    chk("add_wb_clear", busy_mask, 0);

    // vector table, no hazards
    reset_dut();
    iss_ready = 1'b1;
    mask = '0;
    for (int i = 0; i < 15; i++) begin
      instr = vt[i].instr;
      in_valid = 1'b1;
      cur_exp = '{vt[i].fn, vt[i].instr[25:21], vt[i].instr[20:16],
                  vt[i].instr[15:11], vt[i].ill};
      if (!vt[i].ill) mask[vt[i].instr[15:11]] = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    drain();
    cyc();
    chk("tbl_busy", busy_mask, mask);
    chk("tbl_issue_cnt", issue_cnt, 15);
    chk("tbl_stall_cnt", stall_cnt, 0);
    wb(5'd31);
    wb(5'd20);
    chk("wb_noop", busy_mask, mask);
    for (int r = 1; r < 14; r++) wb(5'(r));
    chk("tbl_busy_clear", busy_mask, 0);

    // same-cycle set and clear: set wins
    send(mk(6'h20, 20, 21, 9));
    cyc();
    in_valid = 1'b0;
    wb(5'd9);
    chk("set_wins", busy_mask, 32'h200);
    wb(5'd9);
    cyc();

    // RAW stall
    reset_dut();
    iss_ready = 1'b1;
    send(32'h80221801);
    cyc();
    send(32'h80612000);
    cyc();
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("raw_held", iss_valid, 0);
    chk("raw_stall4", stall_cnt, 4);
    wb(5'd3);
    chk("raw_busy_clr", busy_mask, 0);
    chk("raw_stall5", stall_cnt, 5);
    chk("raw_not_yet", iss_valid, 0);
    cyc();
    chk("raw_issued", iss_valid, 1);
    chk("raw_busy4", busy_mask, 32'h10);
    chk("raw_stall_final", stall_cnt, 5);
    drain();

    // backpressure
    reset_dut();
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      send(mk(6'h20 + 6'(acc), 5'(20 + acc), 5'(24 + acc), 5'(5 + acc)));
      go = in_ready;
      cyc();
      if (go) acc++;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_hold_valid", iss_valid, 1);
    chk("bp_hold_dest", iss_dest, 5);
    iss_ready = 1'b1;
    for (int c = 0; c < 10 && acc < 4; c++) begin
      send(mk(6'h20 + 6'(acc), 5'(20 + acc), 5'(24 + acc), 5'(5 + acc)));
      go = in_ready;
      cyc();
      if (go) acc++;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", acc, 4);
    drain();
    cyc();
    chk("bp_issue_cnt", issue_cnt, 4);
    chk("bp_stall_cnt", stall_cnt, 0);

    // illegal opcode
    reset_dut();
    iss_ready = 1'b1;
    send(32'hFC000000);
    cyc();
    send(mk(6'h20, 0, 0, 1));
    cyc();
    in_valid = 1'b0;
    chk("ill_flag", iss_illegal, 1);
    chk("ill_fn", iss_fn, FN_NOP);
    chk("ill_busy", busy_mask, 0);
    cyc();
    chk("ill_next_valid", iss_valid, 1);
    chk("ill_next_stall", stall_cnt, 0);
    chk("ill_next_busy", busy_mask, 32'h2);
    drain();

    // R31
    reset_dut();
    iss_ready = 1'b1;
    send(32'h8022F800);
    cyc();
    send(mk(6'h21, 31, 31, 31));
    cyc();
    in_valid = 1'b0;
    chk("r31_busy", busy_mask, 0);
    cyc();
    chk("r31_valid", iss_valid, 1);
    chk("r31_stall", stall_cnt, 0);
    chk("r31_busy2", busy_mask, 0);
    drain();

    // reset while hazard-blocked with full FIFO
    reset_dut();
    iss_ready = 1'b1;
    send(mk(6'h20, 1, 2, 3));
    cyc();
    send(mk(6'h20, 3, 1, 4));
    cyc();
    send(mk(6'h21, 3, 2, 5));
    cyc();
    chk("mid_full", in_ready, 0);
    send(mk(6'h22, 3, 3, 6));
    repeat (2) cyc();
    chk("mid_stall", stall_cnt, 3);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    in_valid = 1'b0;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy_mask, 0);
    chk("mid_rst_cnts", {issue_cnt, stall_cnt}, 0);
    chk("mid_rst_iss", {iss_valid, 4'(iss_fn), iss_src1, iss_src2,
                        iss_dest, iss_illegal}, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    chk("mid_rel_in_ready", in_ready, 1);
    cyc();
    chk("mid_rel_empty", iss_valid, 0);
    send(mk(6'h2A, 7, 8, 9));
    cyc();
    in_valid = 1'b0;
    cyc();
    chk("mid_fresh_valid", iss_valid, 1);
    drain();
    cyc();
    chk("mid_fresh_cnt", issue_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
